// File: rtl/pix_stream_tx.sv
// Reads a raster frame from byte-wide frame memory and streams it out as AXI-Stream beats.
// Optional macro PIX_TX_LINE_LAST_EN: axi_last marks the end of every line, not only the frame.
module pix_stream_tx #(
    parameter int MEM_AW = 22,
    parameter int DIM_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    output logic              mem_ren,
    output logic [MEM_AW-1:0] mem_raddr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        axi_data_out,
    output logic              axi_valid,
    input  logic              axi_ready,
    output logic              axi_last,
    output logic              axi_keep,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [DIM_W-1:0]  DIM_ONE  = 1;
    localparam logic [MEM_AW-1:0] ADDR_ONE = 1;

    state_t            r_state;
    state_t            w_next;
    logic [DIM_W-1:0]  r_w;
    logic [DIM_W-1:0]  r_h;
    logic [DIM_W-1:0]  r_col;
    logic [DIM_W-1:0]  r_row;
    logic [MEM_AW-1:0] r_addr;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [7:0]        r_fifo_data [2];
    logic [1:0]        r_fifo_last;
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_cnt;
    logic              r_done;

    logic              w_accept;
    logic              w_zero;
    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_ren;
    logic [2:0]        w_occ;
    logic              w_col_end;
    logic              w_row_end;
    logic              w_fetch_last;
    logic              w_final_beat;
    logic              w_done_set;

    assign w_accept  = start && (r_state == IDLE);
    assign w_zero    = (img_w == '0) || (img_h == '0);
    assign w_valid   = !rst && (r_cnt != 2'd0);
    assign w_pop     = w_valid && axi_ready;
    assign w_push    = r_inflight;
    // Reserve a FIFO slot for every outstanding read so returning data always has room.
    assign w_occ     = {1'b0, r_cnt} + {2'b00, r_inflight};
    assign w_ren     = !rst && (r_state == RUN) && (w_occ < (3'd2 + {2'b00, w_pop}));
    assign w_col_end = (r_col == (r_w - DIM_ONE));
    assign w_row_end = (r_row == (r_h - DIM_ONE));
`ifdef PIX_TX_LINE_LAST_EN
    assign w_fetch_last = w_col_end;
`else
    assign w_fetch_last = w_col_end && w_row_end;
`endif
    assign w_final_beat = w_pop && (r_cnt == 2'd1) && !r_inflight;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_zero) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_next = RUN;
                    end
                end
            end
            RUN: begin
                if (w_ren && w_col_end && w_row_end) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_final_beat) begin
                    w_next     = IDLE;
                    w_done_set = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_w        <= '0;
            r_h        <= '0;
            r_addr     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_done     <= w_done_set;
            r_inflight <= w_ren;
            if (w_accept && !w_zero) begin
                r_w    <= img_w;
                r_h    <= img_h;
                r_addr <= '0;
                r_col  <= '0;
                r_row  <= '0;
            end else if (w_ren) begin
                r_addr <= r_addr + ADDR_ONE;
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= r_row + DIM_ONE;
                end else begin
                    r_col <= r_col + DIM_ONE;
                end
            end
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Payload storage carries no reset; it is only observed through the valid-gated outputs.
    always_ff @(posedge clk) begin
        r_inflight_last <= w_fetch_last;
        if (w_push) begin
            r_fifo_data[r_wptr] <= mem_rdata;
            r_fifo_last[r_wptr] <= r_inflight_last;
        end
    end

    assign mem_ren      = w_ren;
    assign mem_raddr    = rst ? '0 : r_addr;
    assign axi_valid    = w_valid;
    assign axi_data_out = w_valid ? r_fifo_data[r_rptr] : 8'd0;
    assign axi_last     = w_valid && r_fifo_last[r_rptr];
    assign axi_keep     = 1'b1;
    assign busy         = !rst && (r_state != IDLE);
    assign done         = !rst && r_done;

endmodule
